pipe_stage_hs: RTL and testbench
================================

# pipe_stage_hs

Parametrised pipeline stage register with valid/ready handshake, optional skid buffer, synchronous flush and control-bit gating. It is the next generation of the fixed-width MEM→WB register: one instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Payload width and control width are set per instance. Invalid or flushed entries can never assert write-enables downstream.

## Interface
- DATA_W, 32, width of the data payload (ALU result, read data, PC+4, immediates, rd, …, concatenated by the instantiator)
- CTRL_W, 4, width of control payload (regwrite, resultsrc, …); gated to zero whenever the output is not valid
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept an entry this cycle
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control
- out_valid  output  1  entry presented downstream
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  held payload
- out_ctrl  output  CTRL_W  held control AND-ed with out_valid
- count  output  2  entries held (0..2; max 1 when SKID=0)

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (data, ctrl, valid), plus skid register when SKID=1.
- out_data = main data; out_ctrl = main ctrl & {CTRL_W{out_valid}}; out_valid = main valid.
- SKID=1 states: EMPTY (count 0), ONE (count 1), FULL (count 2). in_ready = (state != FULL), driven from a register only.
  - EMPTY: in_fire → ONE, main ← in.
  - ONE: in_fire & out_fire → ONE, main ← in. in_fire & !out_fire → FULL, skid ← in. !in_fire & out_fire → EMPTY. Neither → hold.
  - FULL: out_fire → ONE, main ← skid. Otherwise hold. No input accepted.
- SKID=0: in_ready = !out_valid | out_ready (combinational). in_fire loads main; out_fire without in_fire clears valid. States are EMPTY and ONE only.
- flush (highest priority): next state EMPTY and all valid bits cleared. An in_fire in the same cycle is discarded. Data registers may keep stale contents, but out_ctrl reads 0 from the next cycle.
- Data and ctrl registers load only on accept; they are never modified while held (stall-stable).

## Timing
- Reset (async assert, sync-free release): all valid = 0, state EMPTY, out_valid 0, out_data 0, out_ctrl 0, count 0, in_ready 1.
- Latency: accepted entry appears on out_* the cycle after in_fire.
- Throughput: 1 entry/cycle when out_ready held high, both modes.
- SKID=1: in_ready falls the cycle after the FULL transition. It rises the cycle after the FULL→ONE pop. No ready→ready combinational path.
- SKID=0: combinational path out_ready → in_ready, no other comb paths.
- Order is strictly FIFO. The skid entry is never presented before the main entry.
- Simultaneous flush + out_fire: the downstream transfer counts as completed (it is the consumer's decision). The stage still goes EMPTY.
- Reset asserted mid-stall or mid-FULL: immediate EMPTY, no entry survives.
- in_data/in_ctrl are ignored when in_fire = 0.

## Test plan
- Reset/idle: rst_n=0 with in_valid=1, in_ctrl=4'hF → out_valid=0, out_ctrl=0, count=0, in_ready=1. Release; first clock with in_data=32'h1234 → out_data=32'h1234, out_valid=1 next cycle.
- Streaming: out_ready=1, push 1,2,3,4 on consecutive cycles → same values out on consecutive cycles, 1-cycle latency, count stays 1, in_ready never drops.
- Skid (SKID=1): out_ready=0, push A=32'hA, B=32'hB → count=2, in_ready=0 next cycle, out_data=A stable. C held on input is not accepted. Raise out_ready → A, B, C emerge in order with no loss or duplication.
- Control gating: push ctrl=4'b1001 then deassert in_valid with out_ready=1 → out_ctrl=4'b1001 for one cycle, then 0 while out_data retains its value.
- Flush: in FULL, assert flush with in_valid=1 → next cycle count=0, out_valid=0, out_ctrl=0, in_ready=1. The input of that cycle is never output.
- SKID=0 backpressure: out_ready=0 with one held entry → in_ready=0 in the same cycle. Raise out_ready with in_valid=1 → pass-through replace, count stays 1.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake and an optional two-entry skid buffer.
// Control bits leave the stage only alongside a valid entry, so dead slots never write downstream.
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  assign count     = (state_q == ST_FULL) ? 2'd2 : ((state_q == ST_ONE) ? 2'd1 : 2'd0);

  // With the skid buffer, in_ready is a pure flop output so no ready path crosses the stage.
  assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d     = ST_ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (in_fire && SKID) begin
          state_d     = ST_FULL;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush wins over everything; payload registers may keep stale bits since valid is gone.
    if (flush) begin
      state_d = ST_EMPTY;
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one SKID=1 and one SKID=0 instance, directed stimulus,
// per-instance scoreboards popped by negedge monitors on every downstream transfer.
module tb_pipe_stage_hs;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [3:0]  s_in_ctrl, s_out_ctrl;
  logic [1:0]  s_count;

  logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [31:0] n_in_data, n_out_data;
  logic [3:0]  n_in_ctrl, n_out_ctrl;
  logic [1:0]  n_count;

  int total = 0;
  int bad   = 0;
  ent_t q_s[$];
  ent_t q_n[$];

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(4), .SKID(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .count(s_count)
  );

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(4), .SKID(1'b0)) u_noskid (
    .clk(clk), .rst_n(rst_n), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_ctrl(n_in_ctrl),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
    .count(n_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the skid instance: pop on transfer, then discard or accept the input side.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (s_out_valid && s_out_ready) begin
        if (q_s.size() == 0) begin
          chk("skid_unexpected_output", s_out_data, 32'hDEAD_BEEF);
        end else begin
          e = q_s.pop_front();
          chk("skid_out_data", s_out_data, e.d);
          chk("skid_out_ctrl", 32'(s_out_ctrl), 32'(e.c));
          $display("skid  out data=%0h ctrl=%0h", s_out_data, s_out_ctrl);
        end
      end
      if (s_flush) begin
        q_s.delete();
      end else if (s_in_valid && s_in_ready) begin
        e.d = s_in_data;
        e.c = s_in_ctrl;
        q_s.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (n_out_valid && n_out_ready) begin
        if (q_n.size() == 0) begin
          chk("noskid_unexpected_output", n_out_data, 32'hDEAD_BEEF);
        end else begin
          e = q_n.pop_front();
          chk("noskid_out_data", n_out_data, e.d);
          chk("noskid_out_ctrl", 32'(n_out_ctrl), 32'(e.c));
          $display("noskid out data=%0h ctrl=%0h", n_out_data, n_out_ctrl);
        end
      end
      if (n_flush) begin
        q_n.delete();
      end else if (n_in_valid && n_in_ready) begin
        e.d = n_in_data;
        e.c = n_in_ctrl;
        q_n.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    s_flush = 0; s_in_valid = 1; s_in_data = 32'h0; s_in_ctrl = 4'hF; s_out_ready = 0;
    n_flush = 0; n_in_valid = 1; n_in_data = 32'h0; n_in_ctrl = 4'hF; n_out_ready = 0;
    repeat (2) cycle();

    // Reset with garbage on the input
    chk("rst_s_out_valid", 32'(s_out_valid), 32'd0);
    chk("rst_s_out_ctrl",  32'(s_out_ctrl),  32'd0);
    chk("rst_s_out_data",  s_out_data,       32'd0);
    chk("rst_s_count",     32'(s_count),     32'd0);
    chk("rst_s_in_ready",  32'(s_in_ready),  32'd1);
    chk("rst_n_out_valid", 32'(n_out_valid), 32'd0);
    chk("rst_n_out_ctrl",  32'(n_out_ctrl),  32'd0);
    chk("rst_n_count",     32'(n_count),     32'd0);
    chk("rst_n_in_ready",  32'(n_in_ready),  32'd1);

    s_in_data = 32'h1234; n_in_data = 32'h1234;
    s_out_ready = 1; n_out_ready = 1;
    #2 rst_n = 1'b1;
    cycle();
    chk("first_s_out_valid", 32'(s_out_valid), 32'd1);
    chk("first_s_out_data",  s_out_data,       32'h1234);
    chk("first_n_out_data",  n_out_data,       32'h1234);
    s_in_valid = 0; n_in_valid = 0;
    cycle();
    chk("drain_s_count", 32'(s_count), 32'd0);

    // Streaming 1..4 with out_ready high
    for (int i = 1; i <= 4; i++) begin
      s_in_valid = 1; s_in_data = i; s_in_ctrl = 4'(i);
      n_in_valid = 1; n_in_data = i; n_in_ctrl = 4'(i);
      cycle();
      chk("stream_s_count",    32'(s_count),    32'd1);
      chk("stream_s_in_ready", 32'(s_in_ready), 32'd1);
      chk("stream_s_latency",  s_out_data,      32'(i));
      chk("stream_n_count",    32'(n_count),    32'd1);
      chk("stream_n_latency",  n_out_data,      32'(i));
    end
    s_in_valid = 0; n_in_valid = 0;
    cycle();

    // Skid fill: A, B accepted, C held back until the stage drains
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 32'hA; s_in_ctrl = 4'h1;
    cycle();
    s_in_data = 32'hB; s_in_ctrl = 4'h2;
    cycle();
    chk("skid_full_count",    32'(s_count),    32'd2);
    chk("skid_full_in_ready", 32'(s_in_ready), 32'd0);
    chk("skid_full_data",     s_out_data,      32'hA);
    s_in_data = 32'hC; s_in_ctrl = 4'h3;
    cycle();
    chk("skid_stall_count", 32'(s_count), 32'd2);
    chk("skid_stall_data",  s_out_data,   32'hA);
    s_out_ready = 1;
    cycle();
    chk("skid_pop_data",     s_out_data,      32'hB);
    chk("skid_pop_in_ready", 32'(s_in_ready), 32'd1);
    cycle();
    chk("skid_c_data", s_out_data, 32'hC);
    s_in_valid = 0;
    cycle();
    chk("skid_drained_count", 32'(s_count), 32'd0);

    // Control gating
    s_in_valid = 1; s_in_data = 32'h55; s_in_ctrl = 4'b1001;
    n_in_valid = 1; n_in_data = 32'h55; n_in_ctrl = 4'b1001;
    cycle();
    chk("gate_s_ctrl_live", 32'(s_out_ctrl), 32'h9);
    chk("gate_n_ctrl_live", 32'(n_out_ctrl), 32'h9);
    s_in_valid = 0; n_in_valid = 0;
    cycle();
    chk("gate_s_ctrl_dead",  32'(s_out_ctrl), 32'd0);
    chk("gate_s_valid_dead", 32'(s_out_valid), 32'd0);
    chk("gate_s_data_kept",  s_out_data,      32'h55);
    chk("gate_n_ctrl_dead",  32'(n_out_ctrl), 32'd0);

    // Flush while FULL with a live input
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 32'hD1; s_in_ctrl = 4'hF;
    cycle();
    s_in_data = 32'hD2;
    cycle();
    chk("flush_pre_count", 32'(s_count), 32'd2);
    s_flush = 1; s_in_data = 32'hEE;
    cycle();
    s_flush = 0; s_in_valid = 0;
    chk("flush_s_count",    32'(s_count),     32'd0);
    chk("flush_s_valid",    32'(s_out_valid), 32'd0);
    chk("flush_s_ctrl",     32'(s_out_ctrl),  32'd0);
    chk("flush_s_in_ready", 32'(s_in_ready),  32'd1);
    s_out_ready = 1;
    repeat (2) cycle();

    // Flush coinciding with a downstream transfer on the SKID=0 instance
    n_in_valid = 1; n_in_data = 32'h77; n_in_ctrl = 4'h6;
    cycle();
    n_in_data = 32'h78; n_flush = 1;
    cycle();
    n_flush = 0; n_in_valid = 0;
    chk("flush_n_count", 32'(n_count),    32'd0);
    chk("flush_n_ctrl",  32'(n_out_ctrl), 32'd0);
    repeat (2) cycle();

    // SKID=0 backpressure and pass-through replace
    n_out_ready = 0;
    n_in_valid = 1; n_in_data = 32'h100; n_in_ctrl = 4'h4;
    cycle();
    n_in_data = 32'h200; n_in_ctrl = 4'h5;
    #1;
    chk("bp_n_in_ready_low", 32'(n_in_ready), 32'd0);
    n_out_ready = 1;
    #1;
    chk("bp_n_in_ready_comb", 32'(n_in_ready), 32'd1);
    cycle();
    chk("bp_n_replace_data",  n_out_data,    32'h200);
    chk("bp_n_replace_count", 32'(n_count),  32'd1);
    n_in_valid = 0;
    repeat (2) cycle();

    chk("sb_s_empty", 32'(q_s.size()), 32'd0);
    chk("sb_n_empty", 32'(q_n.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
